// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Moore-style main controller for a multicycle MIPS datapath
//             (lw, sw, R-type, beq, addi, j). Memory states optionally wait
//             on MemReady. A sticky Fault flag records illegal opcodes and
//             unused state encodings.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCEn,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State,
  output logic       Fault
);

  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   w_mem_done;
  logic   w_pc_write;
  logic   w_branch;

  // With MEM_WAIT=0 the memory is assumed to answer in one cycle.
  assign w_mem_done = (MEM_WAIT == 0) || MemReady;

  // Next-state and sticky-fault logic.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      FETCH:  if (w_mem_done) state_d = DECODE;
      DECODE: begin
        case (Op)
          C_OP_LW, C_OP_SW: state_d = MEMADR;
          C_OP_RTYPE:       state_d = EXEC;
          C_OP_BEQ:         state_d = BRANCH;
          C_OP_ADDI:        state_d = ADDIEX;
          C_OP_J:           state_d = JUMP;
          default: begin
            state_d = FETCH;
            fault_d = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (Op == C_OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (w_mem_done) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (w_mem_done) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: begin
        // Unused encoding: recover to FETCH and flag it.
        state_d = FETCH;
        fault_d = 1'b1;
      end
    endcase
  end

  // State and fault registers; reset drops straight into FETCH asynchronously.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Moore output decode; only the FETCH write strobes look at MemReady/Reset
  // so a stalled or held-in-reset fetch never commits IR or PC.
  always_comb begin
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    w_pc_write = 1'b0;
    w_branch   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = w_mem_done && Reset;
        w_pc_write = w_mem_done && Reset;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc      = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn  = w_pc_write | (w_branch & Zero);
  assign State = state_q;
  assign Fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Scoreboard bench for multicycle_control. Two instances are
//             built: one with MEM_WAIT=1 and one with MEM_WAIT=0; each
//             expected-cycle record names the instance it applies to.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMRD  = 4'd3, S_MEMWB  = 4'd4, S_MEMWR  = 4'd5,
                         S_EXEC   = 4'd6, S_ALUWB  = 4'd7, S_BRANCH = 4'd8,
                         S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP  = 4'd11;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Op = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;

  logic iord1, mrd1, mwr1, irw1, rdst1, m2r1, rw1, asa1, pcen1, flt1;
  logic [1:0] asb1, aop1, pcs1;
  logic [3:0] st1;
  logic iord0, mrd0, mwr0, irw0, rdst0, m2r0, rw0, asa0, pcen0, flt0;
  logic [1:0] asb0, aop0, pcs0;
  logic [3:0] st0;
  logic [14:0] ctl1, ctl0;

  multicycle_control #(.MEM_WAIT(1)) dut (
    .Clock(Clock), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1), .IRWrite(irw1), .RegDst(rdst1),
    .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(asa1), .PCEn(pcen1), .ALUSrcB(asb1),
    .ALUOp(aop1), .PCSrc(pcs1), .State(st1), .Fault(flt1));

  multicycle_control #(.MEM_WAIT(0)) dut_nowait (
    .Clock(Clock), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0), .IRWrite(irw0), .RegDst(rdst0),
    .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(asa0), .PCEn(pcen0), .ALUSrcB(asb0),
    .ALUOp(aop0), .PCSrc(pcs0), .State(st0), .Fault(flt0));

  assign ctl1 = {iord1, mrd1, mwr1, irw1, rdst1, m2r1, rw1, asa1, pcen1, asb1, aop1, pcs1};
  assign ctl0 = {iord0, mrd0, mwr0, irw0, rdst0, m2r0, rw0, asa0, pcen0, asb0, aop0, pcs0};

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        sel;   // 1: MEM_WAIT=1 instance, 0: MEM_WAIT=0 instance
    logic [3:0]  st;
    logic        flt;
    logic [14:0] ctl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  logic on_wait = 1'b1;
  logic exp_fault = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Control outputs each state must show, straight from the state table.
  function automatic logic [14:0] exp_ctl(input logic [3:0] st, input logic rdy,
                                          input logic z, input logic mw, input logic rn);
    logic iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcen, go;
    logic [1:0] asb, aop, pcs;
    {iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcen} = 9'd0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    go  = rn && (rdy || !mw);
    case (st)
      S_FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = go; pcen = go; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      S_ALUWB:  begin rw = 1'b1; rdst = 1'b1; end
      S_BRANCH: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pcen = z; end
      S_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      S_ADDIWB: rw = 1'b1;
      S_JUMP:   begin pcs = 2'b10; pcen = 1'b1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcen, asb, aop, pcs};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // One clock cycle of stimulus: drive inputs, log what this cycle must show.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic z);
    exp_t r;
    MemReady = rdy;
    Zero     = z;
    r.sel = on_wait;
    r.st  = st;
    r.flt = exp_fault;
    r.ctl = exp_ctl(st, rdy, z, on_wait, Reset);
    q.push_back(r);
    @(posedge Clock);
    #1;
  endtask

  // Whole instruction: wf stall cycles in FETCH, wm stall cycles in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input logic zb);
    logic go_rdy;
    go_rdy = on_wait;   // the no-wait instance is run with MemReady low
    Op = 6'($urandom);  // IR not yet loaded during fetch
    for (int i = 0; i < wf; i++) cyc(S_FETCH, 1'b0, rbit());
    cyc(S_FETCH, go_rdy, rbit());
    Op = op;
    cyc(S_DECODE, rbit(), rbit());
    case (op)
      OP_LW: begin
        cyc(S_MEMADR, rbit(), rbit());
        for (int i = 0; i < wm; i++) cyc(S_MEMRD, 1'b0, rbit());
        cyc(S_MEMRD, go_rdy, rbit());
        cyc(S_MEMWB, rbit(), rbit());
      end
      OP_SW: begin
        cyc(S_MEMADR, rbit(), rbit());
        for (int i = 0; i < wm; i++) cyc(S_MEMWR, 1'b0, rbit());
        cyc(S_MEMWR, go_rdy, rbit());
      end
      OP_R:    begin cyc(S_EXEC, rbit(), rbit()); cyc(S_ALUWB, rbit(), rbit()); end
      OP_BEQ:  cyc(S_BRANCH, rbit(), zb);
      OP_ADDI: begin cyc(S_ADDIEX, rbit(), rbit()); cyc(S_ADDIWB, rbit(), rbit()); end
      OP_J:    cyc(S_JUMP, rbit(), rbit());
      default: exp_fault = 1'b1;
    endcase
  endtask

  // Reset pulse lasting one cycle at an instruction boundary.
  task automatic do_reset();
    Reset = 1'b0;
    exp_fault = 1'b0;
    cyc(S_FETCH, rbit(), rbit());
    Reset = 1'b1;
  endtask

  function automatic logic [3:0] cur_state();
    return on_wait ? st1 : st0;
  endfunction

  function automatic logic cur_fault();
    return on_wait ? flt1 : flt0;
  endfunction

  function automatic logic cur_rw();
    return on_wait ? rw1 : rw0;
  endfunction

  // R-type aborted by a reset pulse in the middle of its EXEC cycle.
  task automatic reset_in_exec();
    Op = 6'($urandom);
    cyc(S_FETCH, 1'b1, rbit());
    Op = OP_R;
    cyc(S_DECODE, rbit(), rbit());
    chk("exec_reached", cur_state(), S_EXEC);
    #1 Reset = 1'b0;
    #1;
    chk("midreset_state", cur_state(), S_FETCH);
    chk("midreset_fault", cur_fault(), 0);
    chk("midreset_regwrite", cur_rw(), 0);
    exp_fault = 1'b0;
    cyc(S_FETCH, rbit(), rbit());
    Reset = 1'b1;
  endtask

  task automatic random_instr(input int mode_wait);
    int k;
    logic [5:0] op;
    k = $urandom_range(0, 7);
    case (k)
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_R;
      3: op = OP_BEQ;
      4: op = OP_ADDI;
      5: op = OP_J;
      default: begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
    endcase
    if (k == 7) do_reset();
    if (mode_wait != 0)
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    else
      run_instr(op, 0, 0, rbit());
  endtask

  // Monitor: every cycle with a pending record is compared mid-cycle.
  always @(negedge Clock) begin
    ncyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel) begin
        chk($sformatf("state(w1,cyc%0d)", ncyc), st1, e.st);
        chk($sformatf("fault(w1,cyc%0d,st%0d)", ncyc, e.st), flt1, e.flt);
        chk($sformatf("ctl(w1,cyc%0d,st%0d)", ncyc, e.st), ctl1, e.ctl);
      end else begin
        chk($sformatf("state(w0,cyc%0d)", ncyc), st0, e.st);
        chk($sformatf("fault(w0,cyc%0d,st%0d)", ncyc, e.st), flt0, e.flt);
        chk($sformatf("ctl(w0,cyc%0d,st%0d)", ncyc, e.st), ctl0, e.ctl);
      end
    end
  end

  initial begin
    @(posedge Clock);
    #1;
    chk("reset_state_w1", st1, S_FETCH);
    chk("reset_fault_w1", flt1, 0);
    chk("reset_state_w0", st0, S_FETCH);
    chk("reset_fault_w0", flt0, 0);
    cyc(S_FETCH, 1'b1, rbit());      // still in reset: write strobes forced low
    Reset = 1'b1;

    // MEM_WAIT=1 instance: directed scenarios then random mix
    on_wait = 1'b1;
    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 1, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_LW, 1, 2, 1'b0);     // fault must persist
    run_instr(OP_R, 0, 0, 1'b0);
    do_reset();
    reset_in_exec();
    run_instr(OP_ADDI, 2, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    for (int n = 0; n < 60; n++) random_instr(1);

    // MEM_WAIT=0 instance, MemReady held low in memory states
    on_wait = 1'b0;
    do_reset();
    run_instr(OP_J, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 0, 1'b0);
    run_instr(OP_SW, 0, 0, 1'b0);
    for (int n = 0; n < 30; n++) random_instr(0);

    @(negedge Clock);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
